// File: rtl/pocket_array_draw_if.sv
// pocket_array_draw_if: pixel/event inputs and colour/request outputs of the pocket drawer.
interface pocket_array_draw_if;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic               startOfFrame;
    logic [5:0]         pocketEvent;
    logic [7:0]         RGBoutPocket;
    logic               drawingRequestPocket;
    logic [2:0]         pocketIdx;
    logic               pocketsBusy;

    modport master (
        output pixelX, pixelY, startOfFrame, pocketEvent,
        input  RGBoutPocket, drawingRequestPocket, pocketIdx, pocketsBusy
    );
    modport slave (
        input  pixelX, pixelY, startOfFrame, pocketEvent,
        output RGBoutPocket, drawingRequestPocket, pocketIdx, pocketsBusy
    );
endinterface

// File: rtl/pocket_array_draw.sv
// pocket_array_draw: six arithmetic disc pockets with shaded rim and per-pocket blink on ball sink.
module pocket_array_draw #(
    parameter int         TABLE_LEFT   = 16,
    parameter int         TABLE_TOP    = 16,
    parameter int         TABLE_WIDTH  = 608,
    parameter int         TABLE_HEIGHT = 448,
    parameter int         POCKET_SIZE  = 32,
    parameter int         RIM_WIDTH    = 2,
    parameter logic [7:0] CORE_COLOR   = 8'h00,
    parameter logic [7:0] RIM_COLOR    = 8'h49,
    parameter logic [7:0] FLASH_COLOR  = 8'hFC,
    parameter int         FLASH_FRAMES = 8,
    parameter int         BLINK_LOG2   = 1
) (
    input logic clk,
    input logic reset,
    pocket_array_draw_if.slave bus
);
    localparam logic [11:0] S12     = 12'(POCKET_SIZE);
    localparam logic [12:0] SM1     = 13'(POCKET_SIZE - 1);
    localparam logic [25:0] CORE_R2 = 26'(4 * (POCKET_SIZE / 2 - RIM_WIDTH) * (POCKET_SIZE / 2 - RIM_WIDTH));
    localparam logic [25:0] RIM_R2  = 26'(POCKET_SIZE * POCKET_SIZE);
    localparam logic [7:0]  FF8     = 8'(FLASH_FRAMES);

    function automatic int pos_x(input int k);
        return (k % 3 == 0) ? TABLE_LEFT :
               (k % 3 == 1) ? TABLE_LEFT + TABLE_WIDTH / 2 - POCKET_SIZE / 2 :
                              TABLE_LEFT + TABLE_WIDTH - POCKET_SIZE;
    endfunction

    function automatic int pos_y(input int k);
        return (k < 3) ? TABLE_TOP : TABLE_TOP + TABLE_HEIGHT - POCKET_SIZE;
    endfunction

    logic [5:0][7:0] cnt_q, cnt_d;
    logic [7:0]      col [6];
    logic [5:0]      hit, nz;
    logic [7:0]      rgb_q, rgb_d;
    logic [2:0]      idx_q, idx_d, win;
    logic            req_q;

    genvar g;
    for (g = 0; g < 6; g++) begin : g_pocket
        logic signed [11:0] u, v;
        logic signed [12:0] dx, dy;
        logic signed [25:0] dxw, dyw;
        logic [25:0]        d2;
        logic [7:0]         e;
        logic               lit;
        assign u   = {bus.pixelX[10], bus.pixelX} - 12'(pos_x(g));
        assign v   = {bus.pixelY[10], bus.pixelY} - 12'(pos_y(g));
        assign hit[g] = !u[11] && !v[11] && u < S12 && v < S12;
        // centre-doubled coordinates keep the disc centre on an integer grid for even S
        assign dx  = {u, 1'b0} - SM1;
        assign dy  = {v, 1'b0} - SM1;
        assign dxw = 26'(dx);
        assign dyw = 26'(dy);
        assign d2  = dxw * dxw + dyw * dyw;
        assign nz[g] = |cnt_q[g];
        assign e   = FF8 - cnt_q[g];
        assign lit = nz[g] && !e[BLINK_LOG2];
        assign col[g] = (d2 <= CORE_R2) ? (lit ? FLASH_COLOR : CORE_COLOR) :
                        (d2 <= RIM_R2)  ? RIM_COLOR : 8'hFF;
        assign cnt_d[g] = bus.pocketEvent[g] ? FF8 :
                          (bus.startOfFrame && nz[g]) ? cnt_q[g] - 8'd1 : cnt_q[g];
    end

    always_comb begin
        rgb_d = 8'hFF;
        win   = 3'd0;
        for (int k = 5; k >= 0; k--) begin
            if (hit[k]) begin
                rgb_d = col[k];
                win   = 3'(k);
            end
        end
        idx_d = (rgb_d == 8'hFF) ? 3'd0 : win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            rgb_q <= 8'hFF;
            req_q <= 1'b0;
            idx_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            rgb_q <= rgb_d;
            req_q <= rgb_d != 8'hFF;
            idx_q <= idx_d;
        end
    end

    assign bus.RGBoutPocket         = rgb_q;
    assign bus.drawingRequestPocket = req_q;
    assign bus.pocketIdx            = idx_q;
    assign bus.pocketsBusy          = |nz;
endmodule

// File: tb/tb_pocket_array_draw.sv
// tb_pocket_array_draw: scoreboard bench with a frame-level reference model of the pocket drawer.
module tb_pocket_array_draw;
    localparam int L = 16, T = 16, W = 608, H = 448, S = 32, RW = 2;
    localparam int FF = 8, BL = 1;

    typedef struct {
        logic [7:0] rgb;
        logic       req;
        logic [2:0] idx;
        logic       busy;
        int         x, y;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    pocket_array_draw_if bus ();

    pocket_array_draw #(
        .TABLE_LEFT(L), .TABLE_TOP(T), .TABLE_WIDTH(W), .TABLE_HEIGHT(H),
        .POCKET_SIZE(S), .RIM_WIDTH(RW), .CORE_COLOR(8'h00), .RIM_COLOR(8'h49),
        .FLASH_COLOR(8'hFC), .FLASH_FRAMES(FF), .BLINK_LOG2(BL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   tests = 0, failed = 0;
    int   mcnt[6];

    function automatic int px(input int k);
        int c = k % 3;
        return c == 0 ? L : c == 1 ? L + W / 2 - S / 2 : L + W - S;
    endfunction

    function automatic int py(input int k);
        return k < 3 ? T : T + H - S;
    endfunction

    // first hit box wins; colour from squared distance to the box centre in doubled units
    function automatic void model_pix(input int x, input int y, output logic [7:0] rgb, output logic [2:0] idx);
        rgb = 8'hFF;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            if (x >= px(k) && x < px(k) + S && y >= py(k) && y < py(k) + S) begin
                int dx = 2 * (x - px(k)) - (S - 1);
                int dy = 2 * (y - py(k)) - (S - 1);
                int d2 = dx * dx + dy * dy;
                int el = FF - mcnt[k];
                bit lit = mcnt[k] != 0 && ((el / (2 ** BL)) % 2 == 0);
                if (d2 <= 4 * (S / 2 - RW) * (S / 2 - RW)) rgb = lit ? 8'hFC : 8'h00;
                else if (d2 <= 4 * (S / 2) * (S / 2)) rgb = 8'h49;
                idx = rgb == 8'hFF ? 3'd0 : 3'(k);
                return;
            end
        end
    endfunction

    task automatic step(input int x, input int y, input bit sof, input bit [5:0] ev, input bit rst = 0);
        exp_t e;
        @(negedge clk);
        reset = rst;
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        bus.startOfFrame = sof;
        bus.pocketEvent = ev;
        e.x = x;
        e.y = y;
        if (rst) begin
            e.rgb = 8'hFF;
            e.idx = 0;
            foreach (mcnt[k]) mcnt[k] = 0;
        end else begin
            model_pix(x, y, e.rgb, e.idx);
            foreach (mcnt[k]) mcnt[k] = ev[k] ? FF : (sof && mcnt[k] > 0) ? mcnt[k] - 1 : mcnt[k];
        end
        e.req = e.rgb != 8'hFF;
        e.busy = 0;
        foreach (mcnt[k]) if (mcnt[k] != 0) e.busy = 1;
        q.push_back(e);
    endtask

    task automatic frame_probe(input int k);
        step(px(k) + S / 2, py(k) + S / 2, 1, 0);
        step(px(k) + S / 2, py(k) + S / 2, 0, 0);
        step(px(k) + S / 2, py(k) + 1, 0, 0);
        step(-5, 20, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                tests++;
                if (bus.RGBoutPocket !== e.rgb || bus.drawingRequestPocket !== e.req ||
                    bus.pocketIdx !== e.idx || bus.pocketsBusy !== e.busy) begin
                    failed++;
                    $display("FAIL pix(%0d,%0d): got rgb=%h req=%b idx=%0d busy=%b, want rgb=%h req=%b idx=%0d busy=%b",
                             e.x, e.y, bus.RGBoutPocket, bus.drawingRequestPocket, bus.pocketIdx,
                             bus.pocketsBusy, e.rgb, e.req, e.idx, e.busy);
                end
            end
        end
    end

    initial begin
        bus.pixelX = 0;
        bus.pixelY = 0;
        bus.startOfFrame = 0;
        bus.pocketEvent = 0;
        foreach (mcnt[k]) mcnt[k] = 0;
        repeat (3) step(32, 32, 0, 0, 1);
        step(32, 32, 0, 0);
        step(16, 16, 0, 0);
        step(32, 17, 0, 0);
        step(320, 32, 0, 0);
        step(608, 448, 0, 0);
        step(320, 200, 0, 0);
        step(-5, 20, 0, 0);
        step(608, 32, 0, 6'b000100);
        for (int f = 0; f < 11; f++) frame_probe(2);
        step(608, 32, 0, 6'b000100);
        repeat (5) frame_probe(2);
        step(608, 32, 1, 6'b000100);
        repeat (7) frame_probe(2);
        step(608, 32, 0, 6'b000100);
        repeat (10) frame_probe(2);
        step(608, 32, 0, 6'b100101);
        repeat (3) frame_probe(2);
        step(608, 32, 0, 0, 1);
        step(608, 32, 0, 0);
        step(32, 32, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int x, y;
            bit [5:0] ev;
            if ($urandom_range(0, 3) == 0) begin
                x = int'($urandom_range(0, 2047)) - 1024;
                y = int'($urandom_range(0, 2047)) - 1024;
            end else begin
                int k = $urandom_range(0, 5);
                x = px(k) + int'($urandom_range(0, S + 7)) - 4;
                y = py(k) + int'($urandom_range(0, S + 7)) - 4;
            end
            foreach (ev[b]) ev[b] = $urandom_range(0, 99) == 0;
            step(x, y, $urandom_range(0, 15) == 0, ev, $urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        reset = 0;
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/pocket_array_draw.md
Name: pocket_array_draw

Overview:
- Parametrised successor to the single-hole drawer.
- Draws all six table pockets from one instance: four corners plus the top and bottom side-middles. Pocket positions derive from the table geometry parameters.
- Each pocket is rendered arithmetically as a disc with a shaded rim; there is no stored bitmap.
- Each pocket blinks independently for a programmable number of frames when a ball is sunk into it.
- Feeds the background/object mux with RGB, a drawing request and the index of the pocket being drawn.

Parameters:
- TABLE_LEFT, 16: x of the table play-area left edge (pixels).
- TABLE_TOP, 16: y of the table play-area top edge.
- TABLE_WIDTH, 608: play-area width, even.
- TABLE_HEIGHT, 448: play-area height.
- POCKET_SIZE, 32: pocket bounding box side S; even, 8..64.
- RIM_WIDTH, 2: rim band thickness in pixels; must be less than S/2.
- CORE_COLOR, 8'h00: pocket interior colour.
- RIM_COLOR, 8'h49: rim band colour.
- FLASH_COLOR, 8'hFC: interior colour while the blink is lit.
- FLASH_FRAMES, 8: flash duration in frames, 1..255.
- BLINK_LOG2, 1: blink half-period is 2^BLINK_LOG2 frames.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pixelX  in  11 signed  current VGA x
- pixelY  in  11 signed  current VGA y
- startOfFrame  in  1  one-cycle pulse per frame
- pocketEvent  in  6  one-cycle pulse per pocket: ball sunk in pocket k
- RGBoutPocket  out  8  registered colour; 8'hFF = transparent
- drawingRequestPocket  out  1  registered; high when RGBoutPocket != 8'hFF
- pocketIdx  out  3  registered index of the pocket drawn, 0..5; 0 when not drawing
- pocketsBusy  out  1  OR over all pockets of (flash counter != 0)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: RGBoutPocket=8'hFF, drawingRequestPocket=0, pocketIdx=0, all flash counters 0, pocketsBusy=0. Reset has priority over every other input.
- Pocket top-left corners (L=TABLE_LEFT, T=TABLE_TOP, W=TABLE_WIDTH, H=TABLE_HEIGHT, S=POCKET_SIZE):
  - 0: (L, T)
  - 1: (L+W/2-S/2, T)
  - 2: (L+W-S, T)
  - 3: (L, T+H-S)
  - 4: (L+W/2-S/2, T+H-S)
  - 5: (L+W-S, T+H-S)
- In-box test for pocket k: left <= pixelX < left+S and top <= pixelY < top+S, using signed comparison. Negative pixel coordinates are therefore always out of box.
- Overlapping boxes: the lowest k wins.
- Disc test inside the box, with u = pixelX-left and v = pixelY-top:
  - dx = 2u-(S-1), dy = 2v-(S-1), both signed; d2 = dx*dx + dy*dy, unsigned and wide enough for 2*S*S without overflow.
  - Core: d2 <= 4*(S/2-RIM_WIDTH)^2.
  - Rim: otherwise, if d2 <= 4*(S/2)^2.
  - Otherwise transparent (8'hFF).
- Colour selection:
  - Core pixel: FLASH_COLOR if flashOn[k], else CORE_COLOR.
  - Rim pixel: RIM_COLOR always.
- Latency: one clock. Outputs at edge n reflect pixelX/pixelY sampled at edge n. drawingRequestPocket and pocketIdx are registered in the same stage as the colour.
- Flash counter cnt[k], 8 bits, per pocket, updated on each clk:
  - pocketEvent[k]=1: cnt <= FLASH_FRAMES. Retrigger mid-flash reloads.
  - Else, startOfFrame=1 and cnt != 0: cnt <= cnt-1.
  - Else: hold.
  - pocketEvent and startOfFrame in the same cycle: the load wins.
  - Several pocketEvent bits in one cycle: every flagged pocket loads independently.
- flashOn[k]: let e = FLASH_FRAMES - cnt[k]. flashOn = (cnt != 0) and bit BLINK_LOG2 of e equals 0. The first 2^BLINK_LOG2 frames after an event are lit.
- pocketsBusy: combinational OR of (cnt[k] != 0); no extra latency relative to the counters.
- Counter change mid-frame: the new colour takes effect on the next pixel after the update. No frame alignment is applied; upstream is expected to issue pocketEvent during blanking.

Test Plan:
- Defaults, reset held 3 cycles, then released: all outputs at reset values. Pixel (32,32) -> next cycle RGBoutPocket=8'h00, drawingRequestPocket=1, pocketIdx=0 (d2=2).
- Pixel (16,16), pocket 0 corner -> RGBoutPocket=8'hFF, drawingRequestPocket=0, pocketIdx=0 (d2=1922 > 1024). Pixel (32,17) -> 8'h49 rim (d2=842, between 784 and 1024).
- Position sweep:
  - (320,32) -> pocket 1 core, pocketIdx=1.
  - (608,448) -> pocket 5 core, pocketIdx=5.
  - (320,200) and (-5,20) -> transparent.
- Flash, FLASH_FRAMES=8, BLINK_LOG2=1: pulse pocketEvent=6'b000100 -> pocket 2 core shows 8'hFC for frames e=0,1; 8'h00 for e=2,3; 8'hFC for e=4,5; 8'h00 for e=6,7; then 8'h00 permanently. pocketsBusy is high for exactly 8 startOfFrame pulses after the event. Pocket 2 rim stays 8'h49 throughout.
- Same-cycle pocketEvent[2] with startOfFrame while cnt=3 -> cnt=8. Retrigger at cnt=1 -> full 8-frame flash restarts.
- Assert reset mid-flash with cnt=5 -> next cycle cnt=0, pocketsBusy=0, pocket core CORE_COLOR, RGBoutPocket=8'hFF during the reset cycle.
